// File: rtl/decryption_scheduler.sv
// Routes an upstream character stream to one of three cipher engines, then relays that engine's output.
// Forwarding and relaying both take one registered cycle; busy_o holds off upstream while an engine drains.
module decryption_scheduler #(
    parameter int                  D_WIDTH                = 8,
    parameter int                  MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0]  START_DECRYPTION_TOKEN = 8'hFA,
    parameter int                  TIMEOUT                = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             sel_i,
    input  logic [D_WIDTH-1:0]     data_i,
    input  logic                   valid_i,
    output logic                   busy_o,
    output logic [D_WIDTH-1:0]     eng_data_o,
    output logic [2:0]             eng_valid_o,
    input  logic [2:0]             eng_busy_i,
    input  logic [3*D_WIDTH-1:0]   eng_data_i,
    input  logic [2:0]             eng_valid_i,
    output logic [D_WIDTH-1:0]     data_o,
    output logic                   valid_o,
    output logic                   err_o
);

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DRAIN} state_t;

    localparam int CW = $clog2(MAX_NOF_CHARS + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_NOF_CHARS);
    localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT);

    state_t             state, state_d;
    logic [CW-1:0]      count, count_d, count_inc;
    logic [WW-1:0]      wd, wd_d, wd_inc;
    logic [1:0]         sel_q, sel_d;
    logic               seen_busy, seen_busy_d;
    logic               busy_d, err_d, valid_d;
    logic [D_WIDTH-1:0] data_d, eng_data_d;
    logic [2:0]         eng_valid_d;

    logic               in_tok;
    logic [2:0]         sel_oh_i, sel_oh_q;
    logic               eng_vld, eng_bsy;
    logic [D_WIDTH-1:0] eng_dat;

    assign in_tok    = (data_i == START_DECRYPTION_TOKEN);
    assign sel_oh_i  = 3'b001 << sel_i;
    assign sel_oh_q  = 3'b001 << sel_q;
    assign count_inc = count + CW'(1);
    assign wd_inc    = wd + WW'(1);

    // Only the locked engine is observed; the others are don't-care.
    always_comb begin
        eng_vld = 1'b0;
        eng_bsy = 1'b0;
        eng_dat = '0;
        case (sel_q)
            2'd0: begin
                eng_vld = eng_valid_i[0];
                eng_bsy = eng_busy_i[0];
                eng_dat = eng_data_i[0 +: D_WIDTH];
            end
            2'd1: begin
                eng_vld = eng_valid_i[1];
                eng_bsy = eng_busy_i[1];
                eng_dat = eng_data_i[D_WIDTH +: D_WIDTH];
            end
            2'd2: begin
                eng_vld = eng_valid_i[2];
                eng_bsy = eng_busy_i[2];
                eng_dat = eng_data_i[2*D_WIDTH +: D_WIDTH];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state;
        count_d     = count;
        wd_d        = wd;
        sel_d       = sel_q;
        seen_busy_d = seen_busy;
        err_d       = 1'b0;
        eng_valid_d = '0;
        eng_data_d  = eng_data_o;
        valid_d     = 1'b0;
        data_d      = data_o;
        case (state)
            IDLE: begin
                if (valid_i && !in_tok) begin
                    if (sel_i == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d       = sel_i;
                        eng_data_d  = data_i;
                        eng_valid_d = sel_oh_i;
                        count_d     = CW'(1);
                        state_d     = (CW'(1) == CNT_MAX) ? FLUSH : COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (valid_i) begin
                    eng_data_d  = data_i;
                    eng_valid_d = sel_oh_q;
                    if (in_tok) begin
                        state_d     = DRAIN;
                        wd_d        = '0;
                        seen_busy_d = 1'b0;
                    end else begin
                        count_d = count_inc;
                        if (count_inc == CNT_MAX) state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                eng_data_d  = START_DECRYPTION_TOKEN;
                eng_valid_d = sel_oh_q;
                err_d       = 1'b1;
                state_d     = DRAIN;
                wd_d        = '0;
                seen_busy_d = 1'b0;
            end
            DRAIN: begin
                valid_d = eng_vld;
                if (eng_vld) data_d = eng_dat;
                if (eng_bsy) seen_busy_d = 1'b1;
                wd_d = eng_vld ? '0 : wd_inc;
                // A clean completion wins over a watchdog expiring on the same cycle.
                if (seen_busy && !eng_bsy && !eng_vld) begin
                    state_d     = IDLE;
                    seen_busy_d = 1'b0;
                    wd_d        = '0;
                end else if (!eng_vld && wd_inc == WD_MAX) begin
                    state_d     = IDLE;
                    seen_busy_d = 1'b0;
                    wd_d        = '0;
                    err_d       = 1'b1;
                end
            end
        endcase
    end

    assign busy_d = (state_d == FLUSH) || (state_d == DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            wd          <= '0;
            sel_q       <= '0;
            seen_busy   <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
            eng_valid_o <= '0;
            eng_data_o  <= '0;
            valid_o     <= 1'b0;
            data_o      <= '0;
        end else begin
            state       <= state_d;
            count       <= count_d;
            wd          <= wd_d;
            sel_q       <= sel_d;
            seen_busy   <= seen_busy_d;
            busy_o      <= busy_d;
            err_o       <= err_d;
            eng_valid_o <= eng_valid_d;
            eng_data_o  <= eng_data_d;
            valid_o     <= valid_d;
            data_o      <= data_d;
        end
    end

endmodule

// File: tb/tb_decryption_scheduler.sv
// Bench for decryption_scheduler: byte-stream reference model plus a scripted engine with chattering neighbours.
module tb_decryption_scheduler;

    localparam int          DW   = 8;
    localparam int          MAXC = 5;
    localparam int          TMO  = 8;
    localparam logic [7:0]  TOK  = 8'hFA;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    sel_i;
    logic [7:0]    data_i;
    logic          valid_i;
    logic          busy_o;
    logic [7:0]    eng_data_o;
    logic [2:0]    eng_valid_o;
    logic [2:0]    eng_busy_i;
    logic [23:0]   eng_data_i;
    logic [2:0]    eng_valid_i;
    logic [7:0]    data_o;
    logic          valid_o;
    logic          err_o;

    decryption_scheduler #(
        .D_WIDTH(DW), .MAX_NOF_CHARS(MAXC), .START_DECRYPTION_TOKEN(TOK), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .sel_i(sel_i), .data_i(data_i), .valid_i(valid_i),
        .busy_o(busy_o), .eng_data_o(eng_data_o), .eng_valid_o(eng_valid_o),
        .eng_busy_i(eng_busy_i), .eng_data_i(eng_data_i), .eng_valid_i(eng_valid_i),
        .data_o(data_o), .valid_o(valid_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [1:0]  msg_sel[$];
    logic [7:0]  msg_dat[$];
    logic [10:0] act_eng[$], exp_eng[$];
    logic [7:0]  act_out[$], exp_out[$];
    int          act_err, exp_err, cyc, tok_cyc;
    bit          tok_seen, tok_busy, busy_seen, vld_idle;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] oh(input int s);
        logic [2:0] v;
        v = 3'b000;
        v[s] = 1'b1;
        return v;
    endfunction

    // Advance one clock and record everything the DUT shows just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (eng_valid_o != 3'b000) begin
            act_eng.push_back({eng_valid_o, eng_data_o});
            if (eng_data_o == TOK && !tok_seen) begin
                tok_seen = 1'b1;
                tok_cyc  = cyc;
                tok_busy = busy_o;
            end
        end
        if (valid_o) act_out.push_back(data_o);
        if (err_o) act_err++;
        if (busy_o) busy_seen = 1'b1;
        if (valid_o && !busy_o) vld_idle = 1'b1;
    endtask

    // Engine s gets (b, v, d); the other two engines chatter randomly.
    task automatic set_eng(input int s, input bit b, input bit v, input logic [7:0] d);
        logic [31:0] r;
        r = $urandom;
        eng_data_i = r[23:0];
        eng_data_i[s*8 +: 8] = d;
        eng_busy_i = r[26:24];
        eng_busy_i[s] = b;
        eng_valid_i = 3'b111;
        eng_valid_i[s] = v;
    endtask

    task automatic quiet_eng();
        eng_busy_i  = '0;
        eng_valid_i = '0;
        eng_data_i  = '0;
    endtask

    task automatic load(input logic [1:0] sel, input string txt);
        msg_sel.delete();
        msg_dat.delete();
        for (int i = 0; i < txt.len(); i++) begin
            msg_sel.push_back(sel);
            msg_dat.push_back(txt[i]);
        end
        msg_sel.push_back(sel);
        msg_dat.push_back(TOK);
    endtask

    task automatic load_rand(input logic [1:0] sel, input int len);
        logic [7:0] d;
        msg_sel.delete();
        msg_dat.delete();
        for (int i = 0; i < len; i++) begin
            do d = 8'($urandom); while (d == TOK);
            // Later bytes of a legal message carry a random select that must be ignored.
            msg_sel.push_back((i == 0 || sel == 2'd3) ? sel : 2'($urandom_range(0, 3)));
            msg_dat.push_back(d);
        end
        msg_sel.push_back(sel);
        msg_dat.push_back(TOK);
    endtask

    task automatic run_msg(input int nout, input bit hang);
        bit         col, drain;
        int         n, s, w;
        logic [7:0] b, d;
        col = 0; drain = 0; n = 0; s = 0;
        exp_eng.delete(); exp_out.delete(); exp_err = 0;
        act_eng.delete(); act_out.delete(); act_err = 0;
        tok_seen = 0; tok_busy = 0; busy_seen = 0; vld_idle = 0;

        // Reference: what the byte stream should produce, ignoring timing.
        foreach (msg_dat[i]) begin
            if (drain) break;
            b = msg_dat[i];
            if (!col) begin
                if (b != TOK) begin
                    if (msg_sel[i] == 2'd3) begin
                        exp_err++;
                    end else begin
                        s = int'(msg_sel[i]);
                        col = 1; n = 1;
                        exp_eng.push_back({oh(s), b});
                    end
                end
            end else if (b == TOK) begin
                exp_eng.push_back({oh(s), TOK});
                drain = 1;
            end else begin
                n++;
                exp_eng.push_back({oh(s), b});
            end
            if (col && !drain && n == MAXC) begin
                exp_eng.push_back({oh(s), TOK});
                exp_err++;
                drain = 1;
            end
        end

        foreach (msg_dat[i]) begin
            if ($urandom_range(0, 3) == 0) begin
                valid_i = 1'b0;
                tick();
            end
            sel_i = msg_sel[i]; data_i = msg_dat[i]; valid_i = 1'b1;
            tick();
            if (busy_o) begin
                // One more byte while held off; it must vanish.
                if (i + 1 < msg_dat.size()) begin
                    sel_i = msg_sel[i+1]; data_i = msg_dat[i+1];
                    tick();
                end
                break;
            end
        end
        valid_i = 1'b0;

        if (drain) begin
            w = 0;
            while (!tok_seen && w < 8) begin
                tick();
                w++;
            end
            check("tok_seen", 32'(tok_seen), 1);
            check("busy_at_tok", 32'(tok_busy), 1);
            if (hang) begin
                exp_err++;
                w = 0;
                do begin
                    set_eng(s, 1'b1, 1'b0, 8'h00);
                    tick();
                    w++;
                end while (!err_o && w < 4*TMO);
                check("wd_cycles", 32'(cyc - tok_cyc), TMO);
                check("busy_after_wd", 32'(busy_o), 0);
            end else begin
                for (int j = 0; j < nout; j++) begin
                    int g;
                    g = $urandom_range(0, 2);
                    for (int k = 0; k < g; k++) begin
                        set_eng(s, 1'b1, 1'b0, 8'h00);
                        tick();
                    end
                    d = 8'($urandom);
                    set_eng(s, 1'b1, 1'b1, d);
                    exp_out.push_back(d);
                    tick();
                    check("out_lat", {valid_o, data_o}, {1'b1, d});
                end
                set_eng(s, 1'b1, 1'b0, 8'h00);
                tick();
                w = 0;
                do begin
                    set_eng(s, 1'b0, 1'b0, 8'h00);
                    tick();
                    w++;
                end while (busy_o && w < 8);
                check("exit_lat", 32'(w), 1);
                check("drain_exit", 32'(busy_o), 0);
            end
        end
        quiet_eng();
        tick();
        tick();

        check("eng_cnt", 32'(act_eng.size()), 32'(exp_eng.size()));
        for (int i = 0; i < act_eng.size() && i < exp_eng.size(); i++)
            check("eng_fwd", 32'(act_eng[i]), 32'(exp_eng[i]));
        check("out_cnt", 32'(act_out.size()), 32'(exp_out.size()));
        for (int i = 0; i < act_out.size() && i < exp_out.size(); i++)
            check("out_dat", 32'(act_out[i]), 32'(exp_out[i]));
        check("err_cnt", 32'(act_err), 32'(exp_err));
        check("vld_idle", 32'(vld_idle), 0);
        if (!drain) check("busy_idle", 32'(busy_seen), 0);
        if (exp_out.size() > 0) check("out_hold", 32'(data_o), 32'(exp_out[$]));
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_busy"},     32'(busy_o), 0);
        check({pfx, "_valid"},    32'(valid_o), 0);
        check({pfx, "_err"},      32'(err_o), 0);
        check({pfx, "_engvld"},   32'(eng_valid_o), 0);
        check({pfx, "_data"},     32'(data_o), 0);
        check({pfx, "_engdata"},  32'(eng_data_o), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0; tok_cyc = 0;
        rst = 1'b1; sel_i = '0; data_i = '0; valid_i = 1'b0;
        quiet_eng();
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        load(2'd1, "ABCD");   run_msg(3, 1'b0);   // scytale
        load(2'd3, "A");      run_msg(0, 1'b0);   // illegal select
        load(2'd0, "ABCDEF"); run_msg(2, 1'b0);   // overflow
        load(2'd1, "HI");     run_msg(0, 1'b1);   // hung engine
        load(2'd2, "ZZ");     run_msg(3, 1'b0);   // isolation
        load(2'd0, "");       run_msg(0, 1'b0);   // zero length

        // Reset on the third byte of a message, then a fresh message to engine 2.
        sel_i = 2'd0; valid_i = 1'b1;
        data_i = 8'h58; tick();
        data_i = 8'h59; tick();
        rst = 1'b1; data_i = 8'h5A; tick();
        rst = 1'b0; valid_i = 1'b0;
        check_zero("midrst");
        load(2'd2, "PQR");    run_msg(2, 1'b0);

        for (int m = 0; m < 40; m++) begin
            load_rand(2'($urandom_range(0, 3)), $urandom_range(0, 7));
            run_msg($urandom_range(0, 4), ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decryption_scheduler.md
DECRYPTION_SCHEDULER -- requirements
Module: decryption_scheduler

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, character width.
REQ-002 SHALL have parameter MAX_NOF_CHARS, default 50, maximum characters forwarded per message.
REQ-003 SHALL have parameter START_DECRYPTION_TOKEN, default 8'hFA, end-of-message / start-decryption marker.
REQ-004 SHALL have parameter TIMEOUT, default 255, the limit on consecutive DRAIN cycles with no engine output.
REQ-005 SHALL have port clk  in  1  system clock; all logic on posedge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port sel_i  in  2  engine select: 0 caesar, 1 scytale, 2 zigzag, 3 illegal.
REQ-008 SHALL have port data_i  in  D_WIDTH  upstream character.
REQ-009 SHALL have port valid_i  in  1  upstream character strobe.
REQ-010 SHALL have port busy_o  out  1  upstream must hold off; input ignored while high.
REQ-011 SHALL have port eng_data_o  out  D_WIDTH  character broadcast to all engines.
REQ-012 SHALL have port eng_valid_o  out  3  one-hot engine strobe; bit k targets engine k.
REQ-013 SHALL have port eng_busy_i  in  3  per-engine busy.
REQ-014 SHALL have port eng_data_i  in  3*D_WIDTH  per-engine output; engine k occupies bits [k*D_WIDTH +: D_WIDTH].
REQ-015 SHALL have port eng_valid_i  in  3  per-engine output strobe.
REQ-016 SHALL have port data_o  out  D_WIDTH  decrypted character.
REQ-017 SHALL have port valid_o  out  1  decrypted character strobe.
REQ-018 SHALL have port err_o  out  1  single-cycle error pulse.

Function
REQ-019 SHALL implement states IDLE, COLLECT, FLUSH, DRAIN; all outputs registered.
REQ-020 IDLE: valid_i with data_i == token SHALL be ignored; state unchanged.
REQ-021 IDLE: valid_i, non-token data, sel_i 0..2: latch sel_i into sel_q, forward byte, count = 1, go to COLLECT.
REQ-022 IDLE: valid_i, non-token data, sel_i == 3: drop byte, pulse err_o one cycle, stay in IDLE.
REQ-023 Forwarding: eng_data_o = byte and eng_valid_o = (1 << sel_q), both the cycle after acceptance; eng_valid_o SHALL otherwise be 0.
REQ-024 COLLECT: sel_i SHALL be ignored; each valid non-token byte is forwarded and count increments.
REQ-025 COLLECT: valid_i with the token SHALL forward the token and go to DRAIN; count is not incremented.
REQ-026 Overflow: when count reaches MAX_NOF_CHARS, go to FLUSH.
REQ-027 FLUSH: emit the token to engine sel_q for one cycle, pulse err_o, go to DRAIN.
REQ-028 FLUSH: any valid_i SHALL be discarded.
REQ-029 busy_o SHALL be 0 in IDLE/COLLECT and 1 in FLUSH/DRAIN; it is registered with the state.
REQ-030 DRAIN: data_o/valid_o = eng_data_i/eng_valid_i of engine sel_q, delayed one cycle; all other engines' outputs are ignored.
REQ-031 valid_o SHALL be 0 outside DRAIN; data_o holds its last value when valid_o is 0.
REQ-032 DRAIN: flag seen_busy is set when eng_busy_i[sel_q] == 1.
REQ-033 DRAIN: return to IDLE when seen_busy == 1 and eng_busy_i[sel_q] == 0 and eng_valid_i[sel_q] == 0.
REQ-034 DRAIN: a watchdog counts consecutive cycles with eng_valid_i[sel_q] == 0; it clears on each engine valid.
REQ-035 Watchdog: on reaching TIMEOUT, pulse err_o, clear seen_busy, go to IDLE.
REQ-036 count width SHALL be clog2(MAX_NOF_CHARS+1); watchdog width SHALL be clog2(TIMEOUT+1); neither wraps.
REQ-037 Zero-length message (token as first byte in IDLE) SHALL produce no engine activity.

Reset
REQ-038 While rst == 1 at posedge: state IDLE; busy_o, valid_o, err_o, eng_valid_o = 0; data_o, eng_data_o = 0; count, watchdog, sel_q, seen_busy = 0.
REQ-039 Reset mid-message (any state) SHALL abandon the message with no token emitted; rst has priority over all other inputs.

Verification
REQ-040 Scytale message: sel_i=1; bytes "ABCD" then 8'hFA -> eng_valid_o=3'b010 four times, then with 8'hFA; busy_o=1 after the token; engine outputs appear on data_o one cycle later; IDLE after engine busy falls.
REQ-041 Illegal select: sel_i=3, data 8'h41 -> err_o pulses one cycle; eng_valid_o stays 0; busy_o stays 0.
REQ-042 Overflow: MAX_NOF_CHARS=4, sel_i=0, five bytes with no token -> four forwarded; FLUSH sends 8'hFA; err_o pulses; fifth byte dropped.
REQ-043 Hung engine: TIMEOUT=8; engine busy held high with no valid -> err_o pulses after 8 DRAIN cycles; return to IDLE; busy_o=0.
REQ-044 Isolation: sel_q=2 in DRAIN; engine 0 drives valid -> valid_o stays 0.
REQ-045 Reset at the third COLLECT byte -> all outputs 0 next cycle; a new message with sel_i=2 is accepted and routed to engine 2 only.
